// File: rtl/pf_vf_rtable_lookup.sv
// Per-packet PF/VF routing stage: resolves the destination port at SOP and holds it for the packet.
// Optional build macro PFVF_LOOKUP_DROP_MISS_EN: consume missed packets instead of forwarding them.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_SOP    | next accepted beat is the first beat of a packet
// ST_IN_PKT | inside a packet; beats reuse the held port/miss
module pf_vf_rtable_lookup #(
  parameter int NUM_ENTRIES  = 4,
  parameter int NUM_PORTS    = 4,
  parameter int PF_WIDTH     = 3,
  parameter int VF_WIDTH     = 11,
  parameter int PORT_WIDTH   = 2,
  parameter int DATA_WIDTH   = 512,
  parameter int DEFAULT_PORT = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_ENTRIES*PF_WIDTH-1:0]   rtable_pf,
  input  logic [NUM_ENTRIES*VF_WIDTH-1:0]   rtable_vf,
  input  logic [NUM_ENTRIES-1:0]            rtable_vf_active,
  input  logic [NUM_ENTRIES*PORT_WIDTH-1:0] rtable_port,
  input  logic                              rx_tvalid,
  output logic                              rx_tready,
  input  logic [DATA_WIDTH-1:0]             rx_tdata,
  input  logic                              rx_tlast,
  input  logic [PF_WIDTH-1:0]               rx_pf,
  input  logic [VF_WIDTH-1:0]               rx_vf,
  input  logic                              rx_vf_active,
  output logic                              tx_tvalid,
  input  logic                              tx_tready,
  output logic [DATA_WIDTH-1:0]             tx_tdata,
  output logic                              tx_tlast,
  output logic [PORT_WIDTH-1:0]             tx_port,
  output logic                              tx_miss,
  output logic                              miss_pulse,
  output logic [15:0]                       miss_cnt
);

  typedef enum logic {ST_SOP, ST_IN_PKT} state_t;

  // An out-of-range default falls back to port 0 rather than naming a nonexistent port.
  localparam logic [PORT_WIDTH-1:0] DEF_PORT =
    PORT_WIDTH'((DEFAULT_PORT < NUM_PORTS) ? DEFAULT_PORT : 0);

  state_t                  state, state_nxt;
  logic                    accept;
  logic                    lkp_hit;
  logic [PORT_WIDTH-1:0]   lkp_port;
  logic [PORT_WIDTH-1:0]   held_port;
  logic                    held_miss;
  logic [PORT_WIDTH-1:0]   beat_port;
  logic                    beat_miss;
  logic                    beat_fwd;
  logic                    beat_miss_out;
  logic                    sop_miss;

  assign rx_tready = !tx_tvalid || tx_tready;
  assign accept    = rx_tvalid && rx_tready;

  // Descending scan so the lowest-index match is the last (winning) assignment.
  always_comb begin
    lkp_hit  = 1'b0;
    lkp_port = DEF_PORT;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if ((rtable_pf[i*PF_WIDTH +: PF_WIDTH] == rx_pf) &&
          (rtable_vf_active[i] == rx_vf_active) &&
          (!rx_vf_active || (rtable_vf[i*VF_WIDTH +: VF_WIDTH] == rx_vf))) begin
        lkp_hit  = 1'b1;
        lkp_port = rtable_port[i*PORT_WIDTH +: PORT_WIDTH];
      end
    end
  end

  assign beat_port = (state == ST_SOP) ? lkp_port : held_port;
  assign beat_miss = (state == ST_SOP) ? !lkp_hit : held_miss;
  assign sop_miss  = accept && (state == ST_SOP) && !lkp_hit;

`ifdef PFVF_LOOKUP_DROP_MISS_EN
  assign beat_fwd      = !beat_miss;
  assign beat_miss_out = 1'b0;
`else
  assign beat_fwd      = 1'b1;
  assign beat_miss_out = beat_miss;
`endif

  always_comb begin
    state_nxt = state;
    if (accept) begin
      state_nxt = rx_tlast ? ST_SOP : ST_IN_PKT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_SOP;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held_port <= DEF_PORT;
      held_miss <= 1'b0;
    end else if (accept && (state == ST_SOP)) begin
      held_port <= lkp_port;
      held_miss <= !lkp_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_tvalid <= 1'b0;
      tx_tlast  <= 1'b0;
      tx_port   <= '0;
      tx_miss   <= 1'b0;
    end else if (accept) begin
      tx_tvalid <= beat_fwd;
      if (beat_fwd) begin
        tx_tlast <= rx_tlast;
        tx_port  <= beat_port;
        tx_miss  <= beat_miss_out;
      end
    end else if (tx_tready) begin
      tx_tvalid <= 1'b0;
    end
  end

  // Data path carries no reset; it is only observed while tx_tvalid is high.
  always_ff @(posedge clk) begin
    if (accept && beat_fwd) begin
      tx_tdata <= rx_tdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miss_pulse <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      miss_pulse <= sop_miss;
      if (sop_miss && (miss_cnt != 16'hFFFF)) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
    end
  end

endmodule
